// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: ALU and LSU result channels, long-latency issue
// notification, and the registered register-file write port with busy mask.
interface wb_port_arbiter_if #(
  parameter int unsigned wd_regs_p = 32,
  parameter int unsigned n_regs_p  = 32
);
  localparam int unsigned wd_addr_p = $clog2(n_regs_p);

  // ALU result channel
  logic                 i_alu_valid;
  logic [wd_addr_p-1:0] i_alu_rd;
  logic [wd_regs_p-1:0] i_alu_data;
  logic                 o_alu_ready;

  // LSU / mul-div result channel
  logic                 i_lsu_valid;
  logic [wd_addr_p-1:0] i_lsu_rd;
  logic [wd_regs_p-1:0] i_lsu_data;
  logic                 o_lsu_ready;

  // Long-latency issue notification
  logic                 i_issue_valid;
  logic [wd_addr_p-1:0] i_issue_rd;

  // Register-file write port and pending-destination mask
  logic                 o_wr_en;
  logic [wd_addr_p-1:0] o_wr_addr;
  logic [wd_regs_p-1:0] o_wr_data;
  logic [n_regs_p-1:0]  o_busy_mask;

  // Producer / register-file side
  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    input  o_alu_ready,
    output i_lsu_valid, i_lsu_rd, i_lsu_data,
    input  o_lsu_ready,
    output i_issue_valid, i_issue_rd,
    input  o_wr_en, o_wr_addr, o_wr_data, o_busy_mask
  );

  // Arbiter side
  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    output o_alu_ready,
    input  i_lsu_valid, i_lsu_rd, i_lsu_data,
    output o_lsu_ready,
    input  i_issue_valid, i_issue_rd,
    output o_wr_en, o_wr_addr, o_wr_data, o_busy_mask
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the ALU pipeline and the LSU.
// LSU has priority; the ALU is guaranteed a grant after max_wait_p losses.
// Also tracks destinations of issued long-latency ops for decode RAW stalls.
module wb_port_arbiter #(
  parameter int unsigned wd_regs_p  = 32,
  parameter int unsigned n_regs_p   = 32,
  parameter int unsigned max_wait_p = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_port_arbiter_if.slave  bus
);
  localparam int unsigned wd_addr_p = $clog2(n_regs_p);
  localparam int unsigned wd_cnt_p  = 4;
  localparam logic [wd_cnt_p-1:0] max_wait_lp = wd_cnt_p'(max_wait_p);

  logic                 alu_grant_c;
  logic                 lsu_grant_c;

  logic [wd_cnt_p-1:0]  starve_cnt_d, starve_cnt_q;
  logic                 wr_en_d,      wr_en_q;
  logic [wd_addr_p-1:0] wr_addr_d,    wr_addr_q;
  logic [wd_regs_p-1:0] wr_data_d,    wr_data_q;
  logic [n_regs_p-1:0]  busy_mask_d,  busy_mask_q;

  // Per-cycle grant: LSU wins unless the ALU has waited long enough; nothing is granted in reset
  always_comb begin
    alu_grant_c = 1'b0;
    lsu_grant_c = 1'b0;
    if (rst_n) begin
      alu_grant_c = bus.i_alu_valid &&
                    (!bus.i_lsu_valid || (starve_cnt_q >= max_wait_lp));
      lsu_grant_c = bus.i_lsu_valid && !alu_grant_c;
    end
  end

  assign bus.o_alu_ready = alu_grant_c;
  assign bus.o_lsu_ready = lsu_grant_c;

  // Starvation counter: counts consecutive lost ALU requests, saturating at the limit
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.i_alu_valid || alu_grant_c) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < max_wait_lp) begin
      starve_cnt_d = starve_cnt_q + wd_cnt_p'(1);
    end
  end

  // Next write-port contents; x0 transfers are accepted but never write
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_grant_c) begin
      wr_en_d   = (bus.i_alu_rd != '0);
      wr_addr_d = bus.i_alu_rd;
      wr_data_d = bus.i_alu_data;
    end else if (lsu_grant_c) begin
      wr_en_d   = (bus.i_lsu_rd != '0);
      wr_addr_d = bus.i_lsu_rd;
      wr_data_d = bus.i_lsu_data;
    end
  end

  // Pending-destination mask: LSU writeback clears, issue sets (set wins), x0 never busy
  always_comb begin
    busy_mask_d = busy_mask_q;
    if (lsu_grant_c) begin
      busy_mask_d[bus.i_lsu_rd] = 1'b0;
    end
    if (bus.i_issue_valid && (bus.i_issue_rd != '0)) begin
      busy_mask_d[bus.i_issue_rd] = 1'b1;
    end
    busy_mask_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_mask_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_mask_q  <= busy_mask_d;
    end
  end

  assign bus.o_wr_en     = wr_en_q;
  assign bus.o_wr_addr   = wr_addr_q;
  assign bus.o_wr_data   = wr_data_q;
  assign bus.o_busy_mask = busy_mask_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected writes are queued when a
// transfer is seen and compared one cycle later against the write port.
module tb_wb_port_arbiter;
  localparam int unsigned wd_regs_p  = 32;
  localparam int unsigned n_regs_p   = 32;
  localparam int unsigned wd_addr_p  = $clog2(n_regs_p);
  localparam int unsigned max_wait_p = 3;

  typedef struct {
    logic                 had;
    logic                 en;
    logic [wd_addr_p-1:0] addr;
    logic [wd_regs_p-1:0] data;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  wb_exp_t              sb[$];
  logic [wd_addr_p-1:0] held_addr;
  logic [wd_regs_p-1:0] held_data;
  logic [n_regs_p-1:0]  exp_mask;

  wb_port_arbiter_if #(.wd_regs_p(wd_regs_p), .n_regs_p(n_regs_p)) bus ();

  wb_port_arbiter #(
    .wd_regs_p (wd_regs_p),
    .n_regs_p  (n_regs_p),
    .max_wait_p(max_wait_p)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Record one check result
  task automatic chk(input logic ok, input string tag, input string what,
                     input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // One clock: check readies before the edge, queue the expected write, check after the edge
  task automatic step(input logic exp_alu, input logic exp_lsu, input string tag);
    wb_exp_t e;
    @(negedge clk);
    chk(bus.o_alu_ready === exp_alu, tag, "alu_ready", 64'(bus.o_alu_ready), 64'(exp_alu));
    chk(bus.o_lsu_ready === exp_lsu, tag, "lsu_ready", 64'(bus.o_lsu_ready), 64'(exp_lsu));
    e = '{had: 1'b0, en: 1'b0, addr: '0, data: '0};
    if (bus.i_alu_valid && exp_alu) begin
      e = '{had: 1'b1, en: (bus.i_alu_rd != 0), addr: bus.i_alu_rd, data: bus.i_alu_data};
    end else if (bus.i_lsu_valid && exp_lsu) begin
      e = '{had: 1'b1, en: (bus.i_lsu_rd != 0), addr: bus.i_lsu_rd, data: bus.i_lsu_data};
      exp_mask[bus.i_lsu_rd] = 1'b0;
    end
    if (bus.i_issue_valid && bus.i_issue_rd != 0) exp_mask[bus.i_issue_rd] = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.had) begin
      held_addr = e.addr;
      held_data = e.data;
    end
    chk(bus.o_wr_en === e.en, tag, "wr_en", 64'(bus.o_wr_en), 64'(e.en));
    chk(bus.o_wr_addr === held_addr, tag, "wr_addr", 64'(bus.o_wr_addr), 64'(held_addr));
    chk(bus.o_wr_data === held_data, tag, "wr_data", 64'(bus.o_wr_data), 64'(held_data));
    chk(bus.o_busy_mask === exp_mask, tag, "busy_mask", 64'(bus.o_busy_mask), 64'(exp_mask));
  endtask

  task automatic drive_alu(input logic v, input logic [wd_addr_p-1:0] rd, input logic [wd_regs_p-1:0] d);
    bus.i_alu_valid = v;
    bus.i_alu_rd    = rd;
    bus.i_alu_data  = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [wd_addr_p-1:0] rd, input logic [wd_regs_p-1:0] d);
    bus.i_lsu_valid = v;
    bus.i_lsu_rd    = rd;
    bus.i_lsu_data  = d;
  endtask

  task automatic drive_issue(input logic v, input logic [wd_addr_p-1:0] rd);
    bus.i_issue_valid = v;
    bus.i_issue_rd    = rd;
  endtask

  initial begin
    held_addr = '0;
    held_data = '0;
    exp_mask  = '0;

    // Reset with every requester active: readies must stay low
    rst_n = 1'b0;
    drive_alu(1'b1, 5'd5, 32'hA5A5_A5A5);
    drive_lsu(1'b1, 5'd6, 32'h5A5A_5A5A);
    drive_issue(1'b1, 5'd8);
    repeat (2) begin
      @(negedge clk);
      chk(bus.o_alu_ready === 1'b0, "reset", "alu_ready", 64'(bus.o_alu_ready), 64'd0);
      chk(bus.o_lsu_ready === 1'b0, "reset", "lsu_ready", 64'(bus.o_lsu_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_alu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0);
    drive_issue(1'b0, '0);
    @(posedge clk);
    #1;
    chk(bus.o_wr_en === 1'b0, "reset", "wr_en", 64'(bus.o_wr_en), 64'd0);
    chk(bus.o_wr_addr === 5'd0, "reset", "wr_addr", 64'(bus.o_wr_addr), 64'd0);
    chk(bus.o_wr_data === 32'd0, "reset", "wr_data", 64'(bus.o_wr_data), 64'd0);
    chk(bus.o_busy_mask === 32'd0, "reset", "busy_mask", 64'(bus.o_busy_mask), 64'd0);

    // ALU alone
    drive_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, "alu_only");
    chk(bus.o_wr_addr === 5'd5, "alu_only", "wr_addr_const", 64'(bus.o_wr_addr), 64'd5);
    drive_alu(1'b0, '0, '0);
    step(1'b0, 1'b0, "alu_only_idle");

    // Conflict: LSU first, then ALU
    drive_lsu(1'b1, 5'd3, 32'h11);
    drive_alu(1'b1, 5'd4, 32'h22);
    step(1'b0, 1'b1, "conflict0");
    chk(bus.o_wr_addr === 5'd3, "conflict0", "wr_addr_const", 64'(bus.o_wr_addr), 64'd3);
    drive_lsu(1'b0, '0, '0);
    step(1'b1, 1'b0, "conflict1");
    chk(bus.o_wr_addr === 5'd4, "conflict1", "wr_addr_const", 64'(bus.o_wr_addr), 64'd4);
    drive_alu(1'b0, '0, '0);
    step(1'b0, 1'b0, "conflict_idle");

    // Starvation guard: ALU wins on its 4th requesting cycle
    drive_alu(1'b1, 5'd10, 32'hAAAA_0010);
    for (int i = 0; i < 3; i++) begin
      drive_lsu(1'b1, 5'(11 + i), 32'h100 + 32'(i));
      step(1'b0, 1'b1, "starve_lose");
    end
    drive_lsu(1'b1, 5'd14, 32'h103);
    step(1'b1, 1'b0, "starve_win");
    drive_alu(1'b0, '0, '0);
    step(1'b0, 1'b1, "starve_lsu_drain");
    // Counter cleared: LSU wins again on a fresh conflict
    drive_alu(1'b1, 5'd15, 32'h15);
    drive_lsu(1'b1, 5'd16, 32'h16);
    step(1'b0, 1'b1, "starve_reset_cnt");
    drive_lsu(1'b0, '0, '0);
    step(1'b1, 1'b0, "starve_alu_after");
    drive_alu(1'b0, '0, '0);
    step(1'b0, 1'b0, "starve_idle");

    // x0 write: accepted, no write enable
    drive_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, "x0_write");
    chk(bus.o_wr_en === 1'b0, "x0_write", "wr_en_const", 64'(bus.o_wr_en), 64'd0);
    drive_alu(1'b0, '0, '0);
    step(1'b0, 1'b0, "x0_idle");

    // Scoreboard: set on issue, clear on LSU writeback
    drive_issue(1'b1, 5'd7);
    step(1'b0, 1'b0, "sb_issue7");
    chk(bus.o_busy_mask[7] === 1'b1, "sb_issue7", "bit7", 64'(bus.o_busy_mask[7]), 64'd1);
    drive_issue(1'b0, '0);
    drive_lsu(1'b1, 5'd7, 32'h77);
    step(1'b0, 1'b1, "sb_clear7");
    chk(bus.o_busy_mask[7] === 1'b0, "sb_clear7", "bit7", 64'(bus.o_busy_mask[7]), 64'd0);
    chk(bus.o_wr_en === 1'b1, "sb_clear7", "wr_en_const", 64'(bus.o_wr_en), 64'd1);
    drive_lsu(1'b0, '0, '0);
    drive_issue(1'b1, 5'd9);
    step(1'b0, 1'b0, "sb_issue9");
    // Simultaneous clear and re-issue of r9: set wins
    drive_lsu(1'b1, 5'd9, 32'h99);
    step(1'b0, 1'b1, "sb_set_wins");
    chk(bus.o_busy_mask[9] === 1'b1, "sb_set_wins", "bit9", 64'(bus.o_busy_mask[9]), 64'd1);
    drive_lsu(1'b0, '0, '0);
    drive_issue(1'b1, 5'd0);
    step(1'b0, 1'b0, "sb_issue0");
    chk(bus.o_busy_mask === 32'h0000_0200, "sb_issue0", "mask_const", 64'(bus.o_busy_mask), 64'h200);
    drive_issue(1'b0, '0);
    step(1'b0, 1'b0, "final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
